// File: rtl/uart_rx_frontend.sv
// UART receive front end: 2-flop synchroniser, 8N1 deserialiser (8E1 when RX_PARITY_EN is defined),
// first-word-fall-through byte FIFO with valid/ready output and sticky error flags.
module uart_rx_frontend #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx,
    output logic [PAYLOAD_BITS-1:0]       rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_error,
    output logic                          overrun,
    output logic                          parity_error,
    input  logic                          clear_errors
);

    localparam int CPB = CLK_FREQ / BIT_RATE;
    localparam int TW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

    localparam logic [TW-1:0] HALF_M1  = TW'(CPB / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CPB - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and re-arm qualifier
    // ------------------------------------------------------------------
    logic       rx_meta_reg;
    logic       rx_s_reg;
    logic [1:0] fill_reg;
    logic       armed_reg;

    // armed_reg only rises once rx_s carries real line data and that data is high,
    // so a line already low when reset releases is not mistaken for a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            fill_reg    <= 2'b00;
            armed_reg   <= 1'b0;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            fill_reg    <= {fill_reg[0], 1'b1};
            armed_reg   <= armed_reg | (fill_reg[1] & rx_s_reg);
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t                  state_reg, state_next;
    logic [TW-1:0]           tick_reg, tick_next;
    logic [BW-1:0]           bit_reg, bit_next;
    logic [PAYLOAD_BITS-1:0] shift_reg, shift_next;
    logic                    push;
    logic                    pop;
    logic                    set_ferr;
    logic                    set_ovr;
    logic                    set_perr;
    logic                    parity_ok;
    logic                    par_bad_next;
    logic                    ferr_reg;
    logic                    ovr_reg;

`ifdef RX_PARITY_EN
    logic par_bad_reg;
    logic perr_reg;
    assign parity_ok    = ~par_bad_reg;
    assign parity_error = perr_reg;
`else
    assign parity_ok    = 1'b1;
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        push         = 1'b0;
        set_ferr     = 1'b0;
        set_ovr      = 1'b0;
        set_perr     = 1'b0;
        par_bad_next = 1'b0;
`ifdef RX_PARITY_EN
        par_bad_next = par_bad_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                tick_next    = '0;
                bit_next     = '0;
                par_bad_next = 1'b0;
                if (armed_reg && !rx_s_reg) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tick_reg == HALF_M1) begin
                    tick_next  = '0;
                    state_next = rx_s_reg ? ST_IDLE : ST_DATA;
                end else begin
                    tick_next = tick_reg + TW'(1);
                end
            end
            ST_DATA: begin
                if (tick_reg == FULL_M1) begin
                    tick_next  = '0;
                    shift_next = {rx_s_reg, shift_reg[PAYLOAD_BITS-1:1]};
                    if (bit_reg == LAST_BIT) begin
                        bit_next = '0;
`ifdef RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_next = bit_reg + BW'(1);
                    end
                end else begin
                    tick_next = tick_reg + TW'(1);
                end
            end
`ifdef RX_PARITY_EN
            ST_PARITY: begin
                if (tick_reg == FULL_M1) begin
                    tick_next  = '0;
                    state_next = ST_STOP;
                    // Even parity: payload bits plus parity bit must XOR to zero.
                    if (rx_s_reg != ^shift_reg) begin
                        par_bad_next = 1'b1;
                        set_perr     = 1'b1;
                    end
                end else begin
                    tick_next = tick_reg + TW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (tick_reg == FULL_M1) begin
                    tick_next = '0;
                    if (rx_s_reg) begin
                        state_next = ST_IDLE;
                        if (parity_ok) begin
                            if ((fifo_count < DEPTH_C) || pop) begin
                                push = 1'b1;
                            end else begin
                                set_ovr = 1'b1;
                            end
                        end
                    end else begin
                        set_ferr   = 1'b1;
                        state_next = ST_WAIT_IDLE;
                    end
                end else begin
                    tick_next = tick_reg + TW'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set in the same cycle as clear_errors wins
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ferr_reg <= 1'b0;
            ovr_reg  <= 1'b0;
        end else begin
            ferr_reg <= set_ferr | (ferr_reg & ~clear_errors);
            ovr_reg  <= set_ovr  | (ovr_reg  & ~clear_errors);
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bad_reg <= 1'b0;
            perr_reg    <= 1'b0;
        end else begin
            par_bad_reg <= par_bad_next;
            perr_reg    <= set_perr | (perr_reg & ~clear_errors);
        end
    end
`else
    logic unused_parity;
    assign unused_parity = set_perr | par_bad_next;
`endif

    assign frame_error = ferr_reg;
    assign overrun     = ovr_reg;

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------
    logic [AW:0]             wr_ptr_reg;
    logic [AW:0]             rd_ptr_reg;
    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign rx_valid   = (fifo_count != '0);
    assign pop        = rx_valid & rx_ready;
    // Gate the head so the port reads zero while empty (storage itself is not reset).
    assign rx_data    = rx_valid ? mem[rd_ptr_reg[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend with CPB=16, FIFO_DEPTH=4: table of frames plus corner-case sequences,
// received bytes checked against a scoreboard queue.
module tb_uart_rx_frontend;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic       clear_errors = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       frame_error;
    logic       overrun;
    logic       parity_error;

    int n_compared = 0;
    int n_mismatched = 0;
    logic [7:0] exp_q[$];

    uart_rx_frontend #(
        .CLK_FREQ(160),
        .BIT_RATE(10),
        .PAYLOAD_BITS(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .fifo_count(fifo_count),
        .frame_error(frame_error),
        .overrun(overrun),
        .parity_error(parity_error),
        .clear_errors(clear_errors)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: every handshake pops the oldest expected byte.
    always @(negedge clk) begin
        if (reset_n && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL pop_unexpected: got 0x%02h, expected no byte", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                $display("pop    data=0x%02h expected=0x%02h", rx_data, e);
                check("pop_data", int'(rx_data), int'(e));
            end
        end
    end

    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        hold(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        $display("frame  data=0x%02h stop=%0d", d, stop);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(stop, CPB);
        rx = 1'b1;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(posedge clk);
        #1;
        clear_errors = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{data: 8'h00, stop: 1'b1, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'h80, stop: 1'b1, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'h01, stop: 1'b1, exp_ferr: 1'b0};
        vecs[4] = '{data: 8'hC3, stop: 1'b0, exp_ferr: 1'b1};
        vecs[5] = '{data: 8'h5A, stop: 1'b1, exp_ferr: 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(rx_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        reset_n = 1'b1;
        idle(20);
        check("rst_data", int'(rx_data), 0);
        check("rst_ferr", int'(frame_error), 0);
        check("rst_ovr", int'(overrun), 0);
        check("rst_perr", int'(parity_error), 0);

        // 1: single frame, exact push-to-visible latency
        rx_ready = 1'b0;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                check("t1_valid_before_stop", int'(rx_valid), 0);
                @(posedge clk);
                #1;
                check("t1_valid", int'(rx_valid), 1);
                check("t1_data", int'(rx_data), 'hA5);
                check("t1_count", int'(fifo_count), 1);
            end
        join
        idle(10);
        check("t1_data_stable", int'(rx_data), 'hA5);
        rx_ready = 1'b1;
        idle(5);
        check("t1_drained", int'(fifo_count), 0);

        // Table of frames with consumer always ready
        for (int i = 0; i < 6; i++) begin
            pulse_clear();
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            idle(20);
            check("vec_ferr", int'(frame_error), int'(vecs[i].exp_ferr));
            check("vec_ovr", int'(overrun), 0);
            check("vec_count", int'(fifo_count), 0);
            check("vec_sb_empty", exp_q.size(), 0);
        end

        // 2: short glitch is not a start bit
        pulse_clear();
        hold(1'b0, 5);
        idle(40);
        check("t2_valid", int'(rx_valid), 0);
        check("t2_ferr", int'(frame_error), 0);
        check("t2_count", int'(fifo_count), 0);

        // 3: break condition yields one frame_error, then reception resumes
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(((8'h3C >> i) & 8'h01) != 0, CPB);
        hold(1'b0, 20);
        check("t3_ferr_set", int'(frame_error), 1);
        pulse_clear();
        hold(1'b0, 19);
        check("t3_ferr_once", int'(frame_error), 0);
        check("t3_count", int'(fifo_count), 0);
        idle(20);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        idle(20);
        check("t3_sb_empty", exp_q.size(), 0);
        check("t3_ferr_clean", int'(frame_error), 0);

        // 4: overrun when five frames arrive with no consumer
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
            idle(4);
        end
        check("t4_count", int'(fifo_count), 4);
        check("t4_ovr", int'(overrun), 1);
        rx_ready = 1'b1;
        idle(10);
        rx_ready = 1'b0;
        check("t4_sb_empty", exp_q.size(), 0);
        check("t4_count_drained", int'(fifo_count), 0);
        check("t4_ovr_sticky", int'(overrun), 1);

        // 5: full FIFO, pop on the STOP-sample cycle lets the new byte in
        pulse_clear();
        check("t5_ovr_cleared", int'(overrun), 0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h21 + 8'(i));
            send_frame(8'h21 + 8'(i), 1'b1);
            idle(4);
        end
        check("t5_full", int'(fifo_count), 4);
        exp_q.push_back(8'h06);
        fork
            send_frame(8'h06, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
            end
        join
        idle(4);
        check("t5_count", int'(fifo_count), 4);
        check("t5_ovr", int'(overrun), 0);
        rx_ready = 1'b1;
        idle(10);
        rx_ready = 1'b0;
        check("t5_sb_empty", exp_q.size(), 0);

        // 6: reset mid-frame discards everything; line low at release is ignored
        send_frame(8'h55, 1'b1);
        idle(4);
        send_frame(8'h33, 1'b0);
        idle(10);
        check("t6_pre_count", int'(fifo_count), 1);
        check("t6_pre_ferr", int'(frame_error), 1);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b1, CPB);
        hold(1'b1, 5);
        reset_n = 1'b0;
        $display("reset  asserted mid-frame");
        hold(1'b0, 3);
        check("t6_rst_valid", int'(rx_valid), 0);
        check("t6_rst_count", int'(fifo_count), 0);
        check("t6_rst_data", int'(rx_data), 0);
        check("t6_rst_ferr", int'(frame_error), 0);
        check("t6_rst_ovr", int'(overrun), 0);
        reset_n = 1'b1;
        hold(1'b0, 30);
        idle(40);
        check("t6_no_ghost_valid", int'(rx_valid), 0);
        check("t6_no_ghost_ferr", int'(frame_error), 0);
        rx_ready = 1'b1;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        idle(20);
        check("t6_sb_empty", exp_q.size(), 0);
        check("t6_count", int'(fifo_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
